// File: rtl/stream_pack_if.sv
// Valid/ready stream carrying a WIDTH-bit payload.
// The receive modport is the consuming side and the send modport is the producing side.
interface stream #(
  parameter int WIDTH = 32
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport send    (output valid, output data, input ready);
  modport receive (input valid, input data, output ready);
endinterface

// File: rtl/stream_pack.sv
// Packs RATIO narrow stream words into one wide word, first word in the lowest lane.
// A flush pulse emits a partially filled, zero-padded word at the end of a burst.
module stream_pack #(
  parameter type T     = logic [31:0],
  parameter int  RATIO = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  stream.receive                 receiver,
  stream.send                    sender,
  input  logic                   flush,
  output logic [$clog2(RATIO):0] lanes
);
  localparam int W  = $bits(T);
  localparam int CW = $clog2(RATIO) + 1;

  typedef logic [RATIO*W-1:0] wide_t;
  typedef logic [CW-1:0]      cnt_t;

  wide_t acc_reg;
  wide_t data_reg;
  wide_t merged;
  cnt_t  count_reg;
  cnt_t  lanes_reg;
  logic  valid_reg;
  logic  pending_reg;

  logic out_free;
  logic last_lane;
  logic accept;
  logic flush_active;
  logic full_xfer;
  logic part_xfer;
  logic xfer;

  assign out_free  = !valid_reg || sender.ready;
  assign last_lane = (count_reg == cnt_t'(RATIO - 1));

  // count never exceeds RATIO-1, so "not last lane" is the same as count < RATIO-1.
  assign receiver.ready = !last_lane || out_free;
  assign accept         = receiver.valid && receiver.ready;

  assign flush_active = flush || pending_reg;
  assign full_xfer    = accept && last_lane;
  assign part_xfer    = !full_xfer && flush_active && out_free &&
                        ((count_reg != '0) || accept);
  assign xfer         = full_xfer || part_xfer;

  // Accumulator with this cycle's accepted word dropped into lane count_reg.
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
      assign merged[gi*W +: W] = (accept && (count_reg == cnt_t'(gi)))
                                 ? receiver.data
                                 : acc_reg[gi*W +: W];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_reg     <= '0;
      count_reg   <= '0;
      lanes_reg   <= '0;
      valid_reg   <= 1'b0;
      pending_reg <= 1'b0;
    end else if (xfer) begin
      valid_reg   <= 1'b1;
      lanes_reg   <= full_xfer ? cnt_t'(RATIO) : cnt_t'(count_reg + cnt_t'(accept));
      acc_reg     <= '0;
      count_reg   <= '0;
      pending_reg <= 1'b0;
    end else begin
      if (sender.ready) begin
        valid_reg <= 1'b0;
      end
      if (accept) begin
        acc_reg   <= merged;
        count_reg <= count_reg + cnt_t'(1);
      end
      // A flush with nothing buffered and nothing arriving is simply dropped.
      pending_reg <= flush_active && ((count_reg != '0) || accept);
    end
  end

  // Payload register needs no reset: it is only meaningful while valid is high.
  always_ff @(posedge clock) begin
    if (xfer) begin
      data_reg <= merged;
    end
  end

  assign sender.valid = valid_reg;
  assign sender.data  = data_reg;
  assign lanes        = lanes_reg;
endmodule

// File: tb/tb_stream_pack.sv
// Directed bench for stream_pack with 8-bit narrow words and RATIO = 4.
// Each task drives one scenario and compares against hand-computed values.
module tb_stream_pack;
  logic       clock;
  logic       reset;
  logic       flush;
  logic [2:0] lanes;

  stream #(.WIDTH(8))  rx ();
  stream #(.WIDTH(32)) tx ();

  stream_pack #(.T(logic [7:0]), .RATIO(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .receiver(rx),
    .sender  (tx),
    .flush   (flush),
    .lanes   (lanes)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] beat_data[$];
  logic [2:0]  beat_lanes[$];
  int          beat_cyc[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (!reset && tx.valid && tx.ready) begin
      beat_data.push_back(tx.data);
      beat_lanes.push_back(lanes);
      beat_cyc.push_back(cyc);
      $display("beat: data=%08h lanes=%0d cycle=%0d", tx.data, lanes, cyc);
    end
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_beats();
    beat_data.delete();
    beat_lanes.delete();
    beat_cyc.delete();
  endtask

  // Offers first, first+step, ... and advances only on acceptance; gives up after max_cycles.
  task automatic drive_words(input logic [7:0] first, input logic [7:0] step,
                             input int n, input int max_cycles, output int sent);
    logic acc_now;
    sent = 0;
    for (int c = 0; c < max_cycles && sent < n; c++) begin
      rx.valid = 1'b1;
      rx.data  = first + 8'(sent) * step;
      #1;
      acc_now = rx.ready;
      cycle();
      if (acc_now) sent++;
    end
    rx.valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (tx.valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", tx.valid);
    end
    checks++;
    if (lanes !== 3'd0) begin
      errors++; $display("FAIL reset_lanes: got %0d want 0", lanes);
    end
    checks++;
    if (rx.ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", rx.ready);
    end
  endtask

  task automatic test_basic_pack();
    int sent;
    tx.ready = 1'b1;
    clear_beats();
    drive_words(8'h11, 8'h11, 4, 4, sent);
    checks++;
    if (sent !== 4) begin
      errors++; $display("FAIL basic_sent: got %0d want 4", sent);
    end
    checks++;
    if (tx.valid !== 1'b1 || tx.data !== 32'h44332211 || lanes !== 3'd4) begin
      errors++;
      $display("FAIL basic_beat: got valid=%b data=%08h lanes=%0d want 1/44332211/4",
               tx.valid, tx.data, lanes);
    end
    cycle();
    checks++;
    if (tx.valid !== 1'b0 || beat_data.size() !== 1) begin
      errors++;
      $display("FAIL basic_drain: got valid=%b beats=%0d want 0/1", tx.valid, beat_data.size());
    end
  endtask

  task automatic test_back_to_back();
    int          sent;
    logic [31:0] exp;
    tx.ready = 1'b1;
    clear_beats();
    drive_words(8'h00, 8'h01, 16, 16, sent);
    cycle();
    cycle();
    checks++;
    if (sent !== 16 || beat_data.size() !== 4) begin
      errors++; $display("FAIL stream_count: got sent=%0d beats=%0d want 16/4", sent, beat_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        checks++;
        if (beat_data[i] !== exp || beat_lanes[i] !== 3'd4) begin
          errors++;
          $display("FAIL stream_beat%0d: got %08h/%0d want %08h/4", i, beat_data[i], beat_lanes[i], exp);
        end
        if (i > 0) begin
          checks++;
          if (beat_cyc[i] - beat_cyc[i-1] !== 4) begin
            errors++;
            $display("FAIL stream_gap%0d: got %0d want 4", i, beat_cyc[i] - beat_cyc[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int sent;
    tx.ready = 1'b0;
    clear_beats();
    drive_words(8'h21, 8'h01, 4, 4, sent);
    drive_words(8'h25, 8'h01, 8, 8, sent);
    checks++;
    if (sent !== 3) begin
      errors++; $display("FAIL bp_accepted: got %0d want 3", sent);
    end
    checks++;
    if (rx.ready !== 1'b0) begin
      errors++; $display("FAIL bp_ready: got %b want 0", rx.ready);
    end
    checks++;
    if (tx.valid !== 1'b1 || tx.data !== 32'h24232221 || lanes !== 3'd4) begin
      errors++;
      $display("FAIL bp_hold: got valid=%b data=%08h lanes=%0d want 1/24232221/4",
               tx.valid, tx.data, lanes);
    end
    tx.ready = 1'b1;
    drive_words(8'h28, 8'h01, 5, 10, sent);
    cycle();
    cycle();
    checks++;
    if (sent !== 5 || beat_data.size() !== 3) begin
      errors++; $display("FAIL bp_resume: got sent=%0d beats=%0d want 5/3", sent, beat_data.size());
    end else begin
      checks++;
      if (beat_data[0] !== 32'h24232221 || beat_data[1] !== 32'h28272625 ||
          beat_data[2] !== 32'h2C2B2A29) begin
        errors++;
        $display("FAIL bp_data: got %08h %08h %08h want 24232221 28272625 2C2B2A29",
                 beat_data[0], beat_data[1], beat_data[2]);
      end
    end
  endtask

  task automatic test_flush();
    int sent;
    tx.ready = 1'b1;
    drive_words(8'hAA, 8'h11, 2, 2, sent);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    checks++;
    if (tx.valid !== 1'b1 || tx.data !== 32'h0000BBAA || lanes !== 3'd2) begin
      errors++;
      $display("FAIL flush_partial: got valid=%b data=%08h lanes=%0d want 1/0000BBAA/2",
               tx.valid, tx.data, lanes);
    end
    cycle();
    drive_words(8'hAA, 8'h11, 2, 2, sent);
    rx.valid = 1'b1;
    rx.data  = 8'hCC;
    flush    = 1'b1;
    cycle();
    rx.valid = 1'b0;
    flush    = 1'b0;
    checks++;
    if (tx.valid !== 1'b1 || tx.data !== 32'h00CCBBAA || lanes !== 3'd3) begin
      errors++;
      $display("FAIL flush_with_word: got valid=%b data=%08h lanes=%0d want 1/00CCBBAA/3",
               tx.valid, tx.data, lanes);
    end
    cycle();
  endtask

  task automatic test_flush_idle_stalled();
    int sent;
    tx.ready = 1'b1;
    clear_beats();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();
    cycle();
    checks++;
    if (tx.valid !== 1'b0 || beat_data.size() !== 0) begin
      errors++;
      $display("FAIL flush_idle: got valid=%b beats=%0d want 0/0", tx.valid, beat_data.size());
    end
    // The dropped flush must not fire on a later single word.
    drive_words(8'h55, 8'h01, 1, 1, sent);
    cycle();
    cycle();
    checks++;
    if (tx.valid !== 1'b0) begin
      errors++; $display("FAIL flush_cleared: got valid=%b want 0", tx.valid);
    end
    tx.ready = 1'b0;
    drive_words(8'h56, 8'h01, 3, 3, sent);
    drive_words(8'h61, 8'h01, 1, 2, sent);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();
    cycle();
    checks++;
    if (tx.valid !== 1'b1 || tx.data !== 32'h58575655 || lanes !== 3'd4) begin
      errors++;
      $display("FAIL flush_stall_hold: got valid=%b data=%08h lanes=%0d want 1/58575655/4",
               tx.valid, tx.data, lanes);
    end
    tx.ready = 1'b1;
    cycle();
    checks++;
    if (tx.valid !== 1'b1 || tx.data !== 32'h00000061 || lanes !== 3'd1) begin
      errors++;
      $display("FAIL flush_stall_emit: got valid=%b data=%08h lanes=%0d want 1/00000061/1",
               tx.valid, tx.data, lanes);
    end
    cycle();
    checks++;
    if (tx.valid !== 1'b0 || beat_data.size() !== 2) begin
      errors++;
      $display("FAIL flush_stall_drain: got valid=%b beats=%0d want 0/2", tx.valid, beat_data.size());
    end
  endtask

  task automatic test_reset_mid();
    int sent;
    tx.ready = 1'b0;
    drive_words(8'h71, 8'h01, 4, 4, sent);
    drive_words(8'h75, 8'h01, 2, 2, sent);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checks++;
    if (tx.valid !== 1'b0 || lanes !== 3'd0 || rx.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b lanes=%0d ready=%b want 0/0/1", tx.valid, lanes, rx.ready);
    end
    tx.ready = 1'b1;
    clear_beats();
    cycle();
    cycle();
    checks++;
    if (tx.valid !== 1'b0) begin
      errors++; $display("FAIL reset_drop: got valid=%b want 0", tx.valid);
    end
    drive_words(8'h81, 8'h01, 4, 4, sent);
    checks++;
    if (tx.valid !== 1'b1 || tx.data !== 32'h84838281 || lanes !== 3'd4) begin
      errors++;
      $display("FAIL reset_clean: got valid=%b data=%08h lanes=%0d want 1/84838281/4",
               tx.valid, tx.data, lanes);
    end
    cycle();
  endtask

  initial begin
    rx.valid = 1'b0;
    rx.data  = 8'h00;
    tx.ready = 1'b1;
    flush    = 1'b0;
    reset    = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    test_reset();
    test_basic_pack();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_flush_idle_stalled();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
